lsu_byte_seq: RTL and testbench

LSU_BYTE_SEQ -- requirements
Module: lsu_byte_seq

---
 rtl/lsu_byte_seq.sv | 171 +++++++++++++++++
 tb/tb_lsu_byte_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer: splits B/H/W accesses into single-byte memory
// cycles, assembles load data little-endian and extends it per access size.
module lsu_byte_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemWrite,
    input  logic [2:0]  MemCtrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RWAIT  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    logic [1:0]  state;
    logic        we_r;
    logic [2:0]  ctrl_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [2:0]  cnt;
    logic [31:0] ldbuf;
    logic [31:0] rdata_r;
    logic        err_r;

    logic        last;
    logic        capture;
    logic [1:0]  cap_idx;
    logic [31:0] ld_next;

    function automatic logic [2:0] nbytes(input logic [2:0] c);
        case (c[1:0])
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    endfunction

    function automatic logic is_bad(input logic we, input logic [2:0] c, input logic [1:0] a);
        case (c)
            MEM_B, MEM_BU: is_bad = 1'b0;
            MEM_H, MEM_HU: is_bad = a[0];
            MEM_W:         is_bad = (a != 2'b00);
            default:       is_bad = 1'b1;
        endcase
        if (we && (c == MEM_BU || c == MEM_HU))
            is_bad = 1'b1;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] c, input logic [31:0] d);
        case (c)
            MEM_B:   extend = {{24{d[7]}}, d[7:0]};
            MEM_H:   extend = {{16{d[15]}}, d[15:0]};
            MEM_BU:  extend = {24'd0, d[7:0]};
            MEM_HU:  extend = {16'd0, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    assign last    = (cnt == nbytes(ctrl_r) - 3'd1);
    // Read data lags its address by one cycle, so byte cnt-1 arrives now;
    // in RWAIT cnt has advanced to N and this picks up the final byte.
    assign capture = ((state == ACCESS) && (cnt != 3'd0)) || (state == RWAIT);
    assign cap_idx = cnt[1:0] - 2'd1;

    always_comb begin
        ld_next = ldbuf;
        if (capture) begin
            case (cap_idx)
                2'd0: ld_next[7:0]   = mem_rdata;
                2'd1: ld_next[15:8]  = mem_rdata;
                2'd2: ld_next[23:16] = mem_rdata;
                2'd3: ld_next[31:24] = mem_rdata;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_r    <= 1'b0;
            ctrl_r  <= 3'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            cnt     <= 3'd0;
            ldbuf   <= 32'd0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_r    <= MemWrite;
                        ctrl_r  <= MemCtrl;
                        addr_r  <= addr;
                        wdata_r <= wdata;
                        cnt     <= 3'd0;
                        ldbuf   <= 32'd0;
                        if (is_bad(MemWrite, MemCtrl, addr[1:0])) begin
                            rdata_r <= 32'd0;
                            err_r   <= 1'b1;
                            state   <= RESP;
                        end else begin
                            state   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    ldbuf <= ld_next;
                    cnt   <= cnt + 3'd1;
                    if (last) begin
                        if (we_r) begin
                            rdata_r <= 32'd0;
                            err_r   <= 1'b0;
                            state   <= RESP;
                        end else begin
                            state   <= RWAIT;
                        end
                    end
                end
                RWAIT: begin
                    ldbuf   <= ld_next;
                    rdata_r <= extend(ctrl_r, ld_next);
                    err_r   <= 1'b0;
                    state   <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = 32'd0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        if (state == ACCESS) begin
            mem_addr = addr_r + {29'd0, cnt};
            mem_we   = we_r;
            if (we_r) begin
                case (cnt[1:0])
                    2'd0: mem_wdata = wdata_r[7:0];
                    2'd1: mem_wdata = wdata_r[15:8];
                    2'd2: mem_wdata = wdata_r[23:16];
                    2'd3: mem_wdata = wdata_r[31:24];
                endcase
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign rdata      = rdata_r;
    assign err        = err_r;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Directed bench for lsu_byte_seq with a small byte-memory model (1-cycle read latency).
module tb_lsu_byte_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        MemWrite;
    logic [2:0]  MemCtrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [7:0]  pl_data = 8'd0;
    int          wr_cnt = 0;
    int          resp_cnt = 0;
    int          tests = 0;
    int          fails = 0;
    int          w0, r0;

    always #5 clk = ~clk;

    lsu_byte_seq dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .MemWrite(MemWrite), .MemCtrl(MemCtrl), .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata), .err(err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_addr] <= pl_data;
        else if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        mem_rdata <= mem[mem_addr[9:0]];
        if (resp_valid)
            resp_cnt <= resp_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick;
        pl_en = 1'b0;
    endtask

    // Present a request for the accept edge, then scramble inputs; returns in cycle 1.
    task automatic issue(input logic we, input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; MemWrite = we; MemCtrl = c; addr = a; wdata = d;
        tick;
        req_valid = 1'b0; MemWrite = ~we; MemCtrl = 3'b010; addr = 32'hDEAD_BEEF; wdata = 32'h5555_5555;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; MemWrite = 1'b0; MemCtrl = 3'b000; addr = 32'd0; wdata = 32'd0;
        @(negedge clk);
        tick;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwdata", {24'd0, mem_wdata}, 32'd0);
        rst = 1'b0;

        // lw 0x100
        poke(10'h100, 8'h78); poke(10'h101, 8'h56); poke(10'h102, 8'h34); poke(10'h103, 8'h12);
        issue(1'b0, 3'b010, 32'h100, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lw_addr%0d", k), mem_addr, 32'h100 + k);
            chk($sformatf("lw_we%0d", k), {31'd0, mem_we}, 32'd0);
            chk($sformatf("lw_ready%0d", k), {31'd0, req_ready}, 32'd0);
            tick;
        end
        chk("lw_c5_resp", {31'd0, resp_valid}, 32'd0);
        chk("lw_c5_maddr", mem_addr, 32'd0);
        tick;
        chk("lw_resp", {31'd0, resp_valid}, 32'd1);
        chk("lw_rdata", rdata, 32'h1234_5678);
        chk("lw_err", {31'd0, err}, 32'd0);
        tick;
        chk("lw_c7_resp", {31'd0, resp_valid}, 32'd0);
        chk("lw_c7_ready", {31'd0, req_ready}, 32'd1);
        chk("lw_hold", rdata, 32'h1234_5678);

        // lb / lbu 0x201
        poke(10'h201, 8'h80);
        issue(1'b0, 3'b000, 32'h201, 32'd0);
        chk("lb_addr", mem_addr, 32'h201);
        tick;
        chk("lb_c2_resp", {31'd0, resp_valid}, 32'd0);
        tick;
        chk("lb_resp", {31'd0, resp_valid}, 32'd1);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        tick;
        issue(1'b0, 3'b100, 32'h201, 32'd0);
        tick; tick;
        chk("lbu_resp", {31'd0, resp_valid}, 32'd1);
        chk("lbu_rdata", rdata, 32'h0000_0080);
        chk("lbu_err", {31'd0, err}, 32'd0);
        tick;

        // sh 0x10
        w0 = wr_cnt;
        issue(1'b1, 3'b001, 32'h10, 32'hAABB_CCDD);
        chk("sh_we1", {31'd0, mem_we}, 32'd1);
        chk("sh_addr1", mem_addr, 32'h10);
        chk("sh_data1", {24'd0, mem_wdata}, 32'hDD);
        tick;
        chk("sh_we2", {31'd0, mem_we}, 32'd1);
        chk("sh_addr2", mem_addr, 32'h11);
        chk("sh_data2", {24'd0, mem_wdata}, 32'hCC);
        tick;
        chk("sh_resp", {31'd0, resp_valid}, 32'd1);
        chk("sh_err", {31'd0, err}, 32'd0);
        chk("sh_rdata", rdata, 32'd0);
        chk("sh_we3", {31'd0, mem_we}, 32'd0);
        tick;
        chk("sh_nwr", wr_cnt - w0, 32'd2);
        chk("sh_mem10", {24'd0, mem[10'h10]}, 32'hDD);
        chk("sh_mem11", {24'd0, mem[10'h11]}, 32'hCC);

        // Error requests
        w0 = wr_cnt;
        issue(1'b0, 3'b010, 32'h102, 32'd0);
        chk("elw_resp", {31'd0, resp_valid}, 32'd1);
        chk("elw_err", {31'd0, err}, 32'd1);
        chk("elw_rdata", rdata, 32'd0);
        chk("elw_maddr", mem_addr, 32'd0);
        tick;
        chk("elw_idle", {31'd0, req_ready}, 32'd1);
        issue(1'b1, 3'b100, 32'h30, 32'h1234_5678);
        chk("esbu_resp", {31'd0, resp_valid}, 32'd1);
        chk("esbu_err", {31'd0, err}, 32'd1);
        chk("esbu_rdata", rdata, 32'd0);
        tick;
        chk("err_nwr", wr_cnt - w0, 32'd0);

        // sw 0x40 aborted by reset
        poke(10'h42, 8'h00);
        w0 = wr_cnt; r0 = resp_cnt;
        issue(1'b1, 3'b010, 32'h40, 32'h1122_3344);
        chk("rsw_we1", {31'd0, mem_we}, 32'd1);
        chk("rsw_addr1", mem_addr, 32'h40);
        tick;
        chk("rsw_addr2", mem_addr, 32'h41);
        chk("rsw_data2", {24'd0, mem_wdata}, 32'h33);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rsw_we3", {31'd0, mem_we}, 32'd0);
        chk("rsw_ready3", {31'd0, req_ready}, 32'd1);
        chk("rsw_resp3", {31'd0, resp_valid}, 32'd0);
        chk("rsw_rdata3", rdata, 32'd0);
        tick; tick; tick;
        chk("rsw_nresp", resp_cnt - r0, 32'd0);
        chk("rsw_nwr", wr_cnt - w0, 32'd2);
        chk("rsw_mem40", {24'd0, mem[10'h40]}, 32'h44);
        chk("rsw_mem42", {24'd0, mem[10'h42]}, 32'h00);

        // Two lh with req_valid held high
        poke(10'h20, 8'h34); poke(10'h21, 8'h92); poke(10'h22, 8'h01); poke(10'h23, 8'h02);
        req_valid = 1'b1; MemWrite = 1'b0; MemCtrl = 3'b001; addr = 32'h20;
        tick;
        addr = 32'h22;
        chk("b2b_addr1", mem_addr, 32'h20);
        tick;
        chk("b2b_addr2", mem_addr, 32'h21);
        chk("b2b_busy", {31'd0, req_ready}, 32'd0);
        tick; tick;
        chk("b2b_resp1", {31'd0, resp_valid}, 32'd1);
        chk("b2b_rdata1", rdata, 32'hFFFF_9234);
        tick;
        chk("b2b_ready5", {31'd0, req_ready}, 32'd1);
        chk("b2b_c5_resp", {31'd0, resp_valid}, 32'd0);
        tick;
        req_valid = 1'b0;
        chk("b2b_addr6", mem_addr, 32'h22);
        tick;
        chk("b2b_addr7", mem_addr, 32'h23);
        tick; tick;
        chk("b2b_resp2", {31'd0, resp_valid}, 32'd1);
        chk("b2b_rdata2", rdata, 32'h0000_0201);
        tick;
        chk("b2b_idle", {31'd0, req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
